hit_arbiter_ctrl: RTL
=====================

# hit_arbiter_ctrl

Per-pixel sequencer for the charge-sharing arbiter in the photon-counting readout. Detects a local discriminator hit, holds the neighbour arbiter enabled for a programmable coincidence window, and samples the arbiter's winner decision. It counts won hits in a CNT_WIDTH counter, enforces a dead time, and hands the count to the column readout through a req/ack snapshot handshake. One instance sits in each pixel, next to the arbiter logic.

## Interface
- CNT_WIDTH, 12: hit counter width.
- WIN_WIDTH, 4: coincidence-window length field width.
- DEAD_WIDTH, 6: dead-time length field width.

- clk  in  1  pixel clock; all logic is on its rising edge.
- rstn  in  1  reset: one clock, synchronous, active-low.
- arbiterEnable  in  1  1 = arbitrate with neighbours; 0 = bypass, count every local hit.
- discOutLocal  in  1  local discriminator output, already synchronised to clk.
- winerAll  in  1  winner decision from the arbiter.
- windowLen  in  WIN_WIDTH  coincidence window; the window lasts windowLen+1 cycles.
- deadLen  in  DEAD_WIDTH  dead time; the dead time lasts deadLen+1 cycles.
- clearOnRead  in  1  clear the counter when a read is accepted.
- arbEnableOut  out  1  enables the arbiter; high in WINDOW and DECIDE.
- readReq  in  1  level request from the column readout.
- readAck  out  1  one-cycle acknowledge; readData is valid in that cycle.
- readData  out  CNT_WIDTH  counter snapshot.
- overflow  out  1  sticky counter overflow.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- discPrev is a register that follows discOutLocal every cycle. hitEdge = discOutLocal & ~discPrev.
- FSM states: IDLE, WINDOW, DECIDE, DEAD, REARM.
  - IDLE, hitEdge with arbiterEnable=1: go to WINDOW, load winCnt = windowLen.
  - IDLE, hitEdge with arbiterEnable=0: increment the counter, go to DEAD.
  - WINDOW: if winCnt==0, go to DECIDE; otherwise decrement winCnt.
  - DECIDE: if winerAll=1, increment the counter. Go to DEAD and load deadCnt = deadLen.
  - DEAD: if deadCnt==0, go to REARM; otherwise decrement deadCnt. discOutLocal is ignored.
  - REARM: go to IDLE once discOutLocal=0. A disc held high is therefore never counted twice.
- windowLen and deadLen are sampled only when the corresponding counter is loaded. Changes while a hit is in flight take effect on the next hit.
- Counter increment is +1 modulo 2^CNT_WIDTH (see Configuration). An increment from all-ones sets overflow.
- Readout:
  - readReq=1 while readAck=0 accepts a read: readData <= pre-update counter value, readAck=1 next cycle.
  - readReq must drop before a second read is accepted. A read is accepted only on a rising edge of readReq.
  - clearOnRead=1 clears the counter and overflow on acceptance.
- Read coinciding with an increment:
  - readData gets the old value.
  - The counter becomes 1 if clearOnRead=1, otherwise old+1.
  - No hit is lost.
- Reads are accepted in any FSM state.

## Timing
- Reset values: FSM=IDLE, counter=0, discPrev=0, arbEnableOut=0, readAck=0, readData=0, overflow=0, busy=0.
- All outputs are registered.
- Cycle-level sequence for a hit sampled at edge t (discPrev=0, arbiterEnable=1):
  - t+1: arbEnableOut=1 and busy=1.
  - DECIDE occupies edge t+windowLen+2; winerAll is sampled there.
  - The counter updates one cycle later.
  - arbEnableOut=0 from t+windowLen+3.
- Bypass hit: counter visible +1 at t+1.
- Minimum hit spacing (arbitrating) = windowLen+deadLen+4 cycles, plus the REARM wait.
- Read latency: readReq high at edge t gives readAck=1 for exactly the cycle after t.
- rstn low at any edge aborts the sequence and returns all state to reset values at that edge. There is no partial count.

## Configuration
- CNT_SATURATE_EN defined: the counter saturates at all-ones. Further increments hold the value and set overflow.
- CNT_SATURATE_EN not defined: the counter wraps to 0 and sets overflow.
- The macro has no other effect.

## Structure
- Package pixel_ctrl_pkg holds:
  - the FSM state enum;
  - the default CNT_WIDTH, WIN_WIDTH and DEAD_WIDTH constants.
- Sub-module hit_counter holds the counter, the overflow flag, the snapshot register, the readReq edge detect and readAck. It takes the increment and clear strobes from the FSM.

## Test plan
- Arbitration win: windowLen=3, deadLen=2, winerAll=1; hit pulse at cycle 10.
  - arbEnableOut high cycles 11–15.
  - Counter reads 1.
  - busy low again after disc falls.
- Arbitration loss: same stimulus with winerAll=0 → counter remains 0, FSM returns to IDLE.
- Bypass: arbiterEnable=0; 5 hits spaced 8 cycles apart, deadLen=2 → count=5, arbEnableOut never high.
- Held disc: discOutLocal held high for 40 cycles → exactly 1 count, FSM waits in REARM until disc falls.
- Read/increment collision: count=7, clearOnRead=1, readReq at the same edge as DECIDE with winerAll=1 → readData=7, counter=1.
- Overflow: CNT_WIDTH=4, 17 bypass hits.
  - With CNT_SATURATE_EN: count=15, overflow=1.
  - Without CNT_SATURATE_EN: count=1, overflow=1.
  - A clearing read returns overflow to 0.

Source files
------------

// File: rtl/pixel_ctrl_pkg.sv
// Shared types and default widths for the per-pixel hit/arbiter sequencer.
package pixel_ctrl_pkg;

  localparam int unsigned CNT_WIDTH_DEF  = 12;
  localparam int unsigned WIN_WIDTH_DEF  = 4;
  localparam int unsigned DEAD_WIDTH_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WINDOW,
    ST_DECIDE,
    ST_DEAD,
    ST_REARM
  } state_t;

endpackage

// File: rtl/hit_counter.sv
// Hit counter with sticky overflow, read snapshot and req/ack read handshake.
// Optional build macro: CNT_SATURATE_EN (saturate at all-ones instead of wrapping).
// Ports:
//   clk, rstn           clock, synchronous active-low reset
//   i_inc               count strobe from the sequencer
//   i_clear_on_read     clear counter and overflow when a read is accepted
//   i_read_req          level read request; accepted on its rising edge
//   o_read_ack          one-cycle acknowledge, o_read_data valid with it
//   o_read_data         counter snapshot
//   o_overflow          sticky overflow flag
module hit_counter #(
  parameter int unsigned CNT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_inc,
  input  logic                 i_clear_on_read,
  input  logic                 i_read_req,
  output logic                 o_read_ack,
  output logic [CNT_WIDTH-1:0] o_read_data,
  output logic                 o_overflow
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_req_prev;
  logic                 w_accept;
  logic                 w_all_ones;
  logic [CNT_WIDTH-1:0] w_inc_val;

  assign w_accept   = i_read_req & ~r_req_prev & ~o_read_ack;
  assign w_all_ones = &r_cnt;

`ifdef CNT_SATURATE_EN
  assign w_inc_val = w_all_ones ? r_cnt : r_cnt + CNT_WIDTH'(1);
`else
  assign w_inc_val = r_cnt + CNT_WIDTH'(1);
`endif

  // Snapshot takes the pre-update value; a clearing read that meets an
  // increment leaves the counter at 1 so the hit is not lost.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt       <= '0;
      r_req_prev  <= 1'b0;
      o_read_ack  <= 1'b0;
      o_read_data <= '0;
      o_overflow  <= 1'b0;
    end else begin
      r_req_prev <= i_read_req;
      o_read_ack <= w_accept;
      if (w_accept) begin
        o_read_data <= r_cnt;
      end
      if (w_accept && i_clear_on_read) begin
        r_cnt      <= i_inc ? CNT_WIDTH'(1) : '0;
        o_overflow <= 1'b0;
      end else if (i_inc) begin
        r_cnt <= w_inc_val;
        if (w_all_ones) begin
          o_overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hit_arbiter_ctrl.sv
// Per-pixel sequencer: hit edge detect, coincidence window for the neighbour
// arbiter, winner sampling, dead time and re-arm, plus the counter readout.
// Optional build macro: CNT_SATURATE_EN (passed through to hit_counter).
// Ports:
//   clk, rstn       clock, synchronous active-low reset
//   arbiterEnable   1 = arbitrate, 0 = count every local hit
//   discOutLocal    synchronised local discriminator
//   winerAll        arbiter winner decision, sampled in DECIDE
//   windowLen       window lasts windowLen+1 cycles
//   deadLen         dead time lasts deadLen+1 cycles
//   clearOnRead     clear counter on accepted read
//   arbEnableOut    arbiter enable, high in WINDOW and DECIDE
//   readReq         level read request
//   readAck         one-cycle acknowledge
//   readData        counter snapshot
//   overflow        sticky overflow
//   busy            state is not IDLE
module hit_arbiter_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int unsigned WIN_WIDTH  = WIN_WIDTH_DEF,
  parameter int unsigned DEAD_WIDTH = DEAD_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  arbiterEnable,
  input  logic                  discOutLocal,
  input  logic                  winerAll,
  input  logic [WIN_WIDTH-1:0]  windowLen,
  input  logic [DEAD_WIDTH-1:0] deadLen,
  input  logic                  clearOnRead,
  output logic                  arbEnableOut,
  input  logic                  readReq,
  output logic                  readAck,
  output logic [CNT_WIDTH-1:0]  readData,
  output logic                  overflow,
  output logic                  busy
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_disc_prev;
  logic [WIN_WIDTH-1:0]  r_win_cnt;
  logic [WIN_WIDTH-1:0]  w_win_nxt;
  logic [DEAD_WIDTH-1:0] r_dead_cnt;
  logic [DEAD_WIDTH-1:0] w_dead_nxt;
  logic                  w_inc;
  logic                  w_hit_edge;

  assign w_hit_edge = discOutLocal & ~r_disc_prev;

  // Next-state and count strobe
  always_comb begin
    w_state_nxt = r_state;
    w_win_nxt   = r_win_cnt;
    w_dead_nxt  = r_dead_cnt;
    w_inc       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit_edge) begin
          if (arbiterEnable) begin
            w_state_nxt = ST_WINDOW;
            w_win_nxt   = windowLen;
          end else begin
            w_inc       = 1'b1;
            w_state_nxt = ST_DEAD;
            w_dead_nxt  = deadLen;
          end
        end
      end
      ST_WINDOW: begin
        if (r_win_cnt == '0) begin
          w_state_nxt = ST_DECIDE;
        end else begin
          w_win_nxt = r_win_cnt - WIN_WIDTH'(1);
        end
      end
      ST_DECIDE: begin
        w_inc       = winerAll;
        w_state_nxt = ST_DEAD;
        w_dead_nxt  = deadLen;
      end
      ST_DEAD: begin
        if (r_dead_cnt == '0) begin
          w_state_nxt = ST_REARM;
        end else begin
          w_dead_nxt = r_dead_cnt - DEAD_WIDTH'(1);
        end
      end
      ST_REARM: begin
        if (!discOutLocal) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_disc_prev  <= 1'b0;
      r_win_cnt    <= '0;
      r_dead_cnt   <= '0;
      arbEnableOut <= 1'b0;
      busy         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_disc_prev  <= discOutLocal;
      r_win_cnt    <= w_win_nxt;
      r_dead_cnt   <= w_dead_nxt;
      arbEnableOut <= (w_state_nxt == ST_WINDOW) || (w_state_nxt == ST_DECIDE);
      busy         <= (w_state_nxt != ST_IDLE);
    end
  end

  hit_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_hit_counter (
    .clk             (clk),
    .rstn            (rstn),
    .i_inc           (w_inc),
    .i_clear_on_read (clearOnRead),
    .i_read_req      (readReq),
    .o_read_ack      (readAck),
    .o_read_data     (readData),
    .o_overflow      (overflow)
  );

endmodule
